// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: receive FSM states, keyboard
// prefix codes and the FIFO entry width.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  // FIFO entry layout: {released, extended, data[7:0]}
  localparam int PS2_ENTRY_W = 10;

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO holding received PS/2 entries.
// The head entry is kept in a register so that it is zero after reset and
// holds its last value while the FIFO is empty.
module ps2_sync_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [PS2_ENTRY_W-1:0]   push_data,
  input  logic                     pop_req,
  output logic [PS2_ENTRY_W-1:0]   head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

  logic [PS2_ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [PS2_ENTRY_W-1:0] head_q, head_d;
  logic                   full, pop_ok, push_ok;

  // Pointer/count bookkeeping and next head value (bypass when the FIFO
  // is empty or drains to the entry being written this cycle).
  always_comb begin
    full     = (count_q == FULL_CNT);
    pop_ok   = pop_req && (count_q != '0);
    push_ok  = push && (!full || pop_ok);
    drop     = push && full && !pop_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + ONE_CNT;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - ONE_CNT;
    end
    head_d = head_q;
    if (pop_ok) begin
      if (count_q > ONE_CNT) begin
        head_d = mem[rd_ptr_d];
      end else if (push_ok) begin
        head_d = push_data;
      end
    end else if ((count_q == '0) && push_ok) begin
      head_d = push_data;
    end
  end

  // Storage array write port (no reset on the data array).
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head  = head_q;
  assign level = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with deglitch filter, frame timeout,
// optional keyboard prefix decoding and a received-byte FIFO.
// Define PS2_RX_ERR_EN to enable bad-frame reporting (err_pulse/err_count);
// otherwise those outputs are tied to zero.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 16,
  parameter int TIMEOUT_CYC = 65535,
  parameter int FIFO_DEPTH  = 8,
  parameter int KBD_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_rcv,
  input  logic                          ps2clk_ext,
  input  logic                          ps2data_ext,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [7:0]                    rd_data,
  output logic                          rd_released,
  output logic                          rd_extended,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          err_pulse,
  output logic [7:0]                    err_count
);

  // A falling edge is a clean run of highs followed by a longer run of lows.
  localparam logic [FILTER_LEN-1:0] FALL_PAT =
    {{(FILTER_LEN / 4){1'b1}}, {(3 * FILTER_LEN / 4){1'b0}}};
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

  logic                  clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic                  dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  ps2_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  pend_ext_q, pend_ext_d;
  logic                  pend_rel_q, pend_rel_d;
  logic                  overflow_q, overflow_d;

  logic                  edge_ok, timed_out, frame_done, frame_good;
  logic                  push;
  logic [PS2_ENTRY_W-1:0] push_word, head;
  logic                  fifo_empty, fifo_drop;

  // Synchronisers and the clock-line sample history.
  always_comb begin
    clk_s1_d = ps2clk_ext;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2data_ext;
    dat_s2_d = dat_s1_q;
    hist_d   = {hist_q[FILTER_LEN-2:0], clk_s2_q};
  end

  // Frame FSM, timeout, frame check, prefix decode and overflow flag.
  always_comb begin
    edge_ok    = (hist_q == FALL_PAT) && enable_rcv;
    timed_out  = (state_q != ST_IDLE) && (to_cnt_q == TO_MAX);
    frame_done = edge_ok && (state_q == ST_STOP) && !timed_out;
    frame_good = frame_done && (^{shreg_q, par_q}) && dat_s2_q;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    if (edge_ok) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (timed_out) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else if (edge_ok) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    push       = 1'b0;
    push_word  = {pend_rel_q, pend_ext_q, shreg_q};
    pend_ext_d = pend_ext_q;
    pend_rel_d = pend_rel_q;
    if (frame_good) begin
      if (KBD_MODE != 0) begin
        if (shreg_q == PS2_PREFIX_EXT) begin
          pend_ext_d = 1'b1;
        end else if (shreg_q == PS2_PREFIX_REL) begin
          pend_rel_d = 1'b1;
        end else begin
          push       = 1'b1;
          pend_ext_d = 1'b0;
          pend_rel_d = 1'b0;
        end
      end else begin
        push      = 1'b1;
        push_word = {2'b00, shreg_q};
      end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
      hist_q     <= '0;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      pend_ext_q <= 1'b0;
      pend_rel_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      hist_q     <= hist_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      pend_ext_q <= pend_ext_d;
      pend_rel_q <= pend_rel_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop_req   (rd_ready),
    .head      (head),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign rd_valid    = !fifo_empty;
  assign rd_data     = head[7:0];
  assign rd_extended = head[8];
  assign rd_released = head[9];
  assign overflow    = overflow_q;

`ifdef PS2_RX_ERR_EN
  logic       frame_bad;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Bad-frame pulse and saturating counter.
  always_comb begin
    frame_bad   = frame_done && !frame_good;
    err_pulse_d = frame_bad;
    err_cnt_d   = err_cnt_q;
    if (frame_bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error reporting registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
`else
  assign err_pulse = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule
